// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master that frames parallel RAM commands for the SPI_wrapper slave.
// Define SPI_MASTER_PROTO_CHECK_EN to reject out-of-order write-data/read-data commands.
module spi_master_ctrl #(
    parameter int RD_LAT     = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       cmd_err,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);
    typedef enum logic [2:0] {IDLE, CHK, SHIFT, WAIT_RD, RECV, GAP} state_t;
    localparam logic [3:0] RD_END  = 4'(RD_LAT - 1);
    localparam logic [3:0] GAP_END = 4'(GAP_CYCLES - 1);
    state_t state, nxt;
    logic [3:0] cnt;
    logic [9:0] sh;
    logic [1:0] typ;
    logic [7:0] rx;
    logic accept, illegal, in_frame;
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign in_frame  = nxt inside {CHK, SHIFT, WAIT_RD, RECV};
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = cmd_valid && !illegal ? CHK : IDLE;
            CHK:     nxt = SHIFT;
            SHIFT:   nxt = cnt != 4'd9 ? SHIFT : typ == 2'b11 ? WAIT_RD : GAP;
            WAIT_RD: nxt = cnt == RD_END ? RECV : WAIT_RD;
            RECV:    nxt = cnt == 4'd7 ? GAP : RECV;
            GAP:     nxt = cnt == GAP_END ? IDLE : GAP;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            typ       <= '0;
            rx        <= '0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state <= nxt;
            cnt   <= nxt != state ? 4'd0 : cnt + 4'd1;
            if (accept) begin
                sh  <= {cmd_type, cmd_data};
                typ <= cmd_type;
            end else if (state == SHIFT) begin
                sh <= {sh[8:0], 1'b0};
            end
            if (state == RECV)
                rx <= {rx[6:0], MISO};
            SS_n <= !in_frame;
            // MOSI is registered, so it is loaded with the bit of the upcoming cycle
            MOSI <= nxt == CHK ? cmd_type[1] : nxt != SHIFT ? 1'b0 : state == CHK ? sh[9] : sh[8];
            rsp_valid <= state == RECV && cnt == 4'd7;
            if (state == RECV && cnt == 4'd7)
                rsp_data <= {rx[6:0], MISO};
        end
    end
`ifdef SPI_MASTER_PROTO_CHECK_EN
    logic [2:0] last;  // {seen, type} of the last completed frame
    assign illegal = (cmd_type == 2'b11 && last != 3'b110) || (cmd_type == 2'b01 && last[2:1] != 2'b10);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last    <= '0;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= accept && illegal;
            if (nxt == GAP && state != GAP)
                last <= {1'b1, typ};
        end
    end
`else
    assign illegal = 1'b0;
    assign cmd_err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed bench for spi_master_ctrl with a frame/response scoreboard
// and a behavioural slave that decodes frames into a small RAM and drives MISO.
module tb_spi_master_ctrl;
    localparam int RD_LAT = 2;
    localparam int GAP    = 2;
    logic clk = 0, rst = 1, cmd_valid = 0, MISO = 0;
    logic [1:0] cmd_type = 0;
    logic [7:0] cmd_data = 0;
    logic cmd_ready, rsp_valid, busy, cmd_err, SS_n, MOSI;
    logic [7:0] rsp_data;
    int checks = 0, errors = 0;
    typedef struct {logic [10:0] bits; int len;} frame_t;
    frame_t exp_q[$];
    frame_t f;
    logic [7:0] rsp_q[$];
    logic [7:0] ram[256];
    logic [7:0] waddr = 0, raddr = 0, rb;
    logic [10:0] cap = 0;
    bit b2b = 0;
    int b2b_acc = 0, b2b_fr = 0, cyc = 0, acc_cyc = 0, lo = 0, gapc = 0;

    spi_master_ctrl #(.RD_LAT(RD_LAT), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .busy(busy), .cmd_err(cmd_err),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // accept-to-accept period while commands are streamed back to back
    always @(posedge clk) begin
        cyc++;
        if (cmd_valid && cmd_ready) begin
            if (b2b && b2b_acc > 0)
                chk("period", cyc - acc_cyc, 12 + GAP);
            acc_cyc = cyc;
            if (b2b) b2b_acc++;
        end
    end

    // frame monitor, slave model and response scoreboard
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            lo = 0;
            MISO = 0;
            cap = 0;
        end else begin
            if (!SS_n) begin
                if (lo == 0 && b2b && b2b_fr > 0)
                    chk("gap", gapc, GAP);
                if (lo <= 10) cap = {cap[9:0], MOSI};
                rb = ram[raddr];
                MISO = (lo >= 11 + RD_LAT && lo < 19 + RD_LAT) ? rb[18 + RD_LAT - lo] : 1'b0;
                lo++;
            end else begin
                if (lo != 0) begin
                    if (exp_q.size() == 0) chk("unexpected_frame", lo, 0);
                    else begin
                        f = exp_q.pop_front();
                        chk("frame_bits", cap, f.bits);
                        chk("frame_len", lo, f.len);
                    end
                    case (cap[9:8])
                        2'b00: waddr = cap[7:0];
                        2'b01: ram[waddr] = cap[7:0];
                        2'b10: raddr = cap[7:0];
                        default: ;
                    endcase
                    gapc = 0;
                    if (b2b) b2b_fr++;
                end
                if (busy) gapc++;
                lo = 0;
                MISO = 0;
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 1'b0);
                else chk("rsp_data", rsp_data, rsp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [1:0] t, input logic [7:0] d, input bit frame, input bit hold,
                        input logic [7:0] rsp);
        int n = 0;
        cmd_type = t;
        cmd_data = d;
        cmd_valid = 1;
        if (frame) begin
            exp_q.push_back('{{t[1], t, d}, t == 2'b11 ? 19 + RD_LAT : 11});
            if (t == 2'b11) rsp_q.push_back(rsp);
        end
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) chk("ready_timeout", cmd_ready, 1'b1);
        @(negedge clk);
        if (!hold) cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n == 300) chk("idle_timeout", busy, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
        repeat (2) @(negedge clk);
        chk("rst_ss", SS_n, 1'b1);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", cmd_err, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        rst = 0;
        @(negedge clk);
`ifdef SPI_MASTER_PROTO_CHECK_EN
        send(2'b11, 8'h00, 0, 0, 8'h00);
        chk("err_pulse", cmd_err, 1'b1);
        chk("err_ss", SS_n, 1'b1);
        @(negedge clk);
        chk("err_clear", cmd_err, 1'b0);
        chk("err_idle", busy, 1'b0);
`else
        send(2'b11, 8'h00, 1, 0, 8'h5A);
        wait_idle();
`endif
        // reset in the middle of a write-addr frame, while MOSI is driving a 1
        send(2'b00, 8'h3C, 0, 0, 8'h00);
        repeat (6) @(negedge clk);
        chk("mid_mosi", MOSI, 1'b1);
        #2 rst = 1;
        #1;
        chk("arst_ss", SS_n, 1'b1);
        chk("arst_mosi", MOSI, 1'b0);
        chk("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1'b1);
        chk("post_rst_rsp", rsp_valid, 1'b0);
        send(2'b00, 8'h3C, 1, 0, 8'h00);
        wait_idle();
        chk("wa_busy", busy, 1'b0);
        chk("wa_ready", cmd_ready, 1'b1);
        send(2'b01, 8'hA5, 1, 0, 8'h00);
        wait_idle();
        chk("ram_3c", ram[8'h3C], 8'hA5);
        send(2'b10, 8'h3C, 1, 0, 8'h00);
        wait_idle();
        send(2'b11, 8'h00, 1, 0, 8'hA5);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("rsp_hold", rsp_data, 8'hA5);
        b2b = 1;
        send(2'b00, 8'h10, 1, 1, 8'h00);
        send(2'b01, 8'h77, 1, 1, 8'h00);
        send(2'b10, 8'h10, 1, 1, 8'h00);
        send(2'b11, 8'hFF, 1, 0, 8'h77);
        wait_idle();
        b2b = 0;
        repeat (3) @(negedge clk);
        chk("frames_left", exp_q.size(), 0);
        chk("rsps_left", rsp_q.size(), 0);
        chk("b2b_frames", b2b_fr, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
